// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stalls, mul/div holds and branch flushes for ID->EX->MEM->WB
// Inputs describe the instruction in ID (sources, destination, load/muldiv flags) plus the EX branch outcome.
// Outputs: registered EX operand selects (1x=EX/MEM, 01=WB, 00=regfile), stall/bubble/hold/flush controls,
// and the mul/div start pulse and busy flag. WB->ID reads rely on register-file write-through, so no WB shadow.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_wr_addr,
  input  logic       id_reg_write,
  input  logic       id_is_load,
  input  logic       id_is_muldiv,
  input  logic       branch_taken_ex,
  output logic [1:0] src_a_mux,
  output logic [1:0] src_b_mux,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       ex_hold,
  output logic       flush_id,
  output logic       muldiv_start,
  output logic       muldiv_busy
);
  localparam int CW = $clog2(MULDIV_LAT + 1);
  typedef struct packed {
    logic       v;
    logic [4:0] wa;
    logic       rw;
    logic       ld;
    logic       md;
  } ex_t;
  ex_t ex_q, ex_d;
  logic mem_v_q, mem_v_d, mem_rw_q, mem_rw_d;
  logic [4:0] mem_wa_q, mem_wa_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic start_q, start_d;
  logic [1:0] sa_q, sa_d, sb_q, sb_d;
  logic ua, ub, ha_ex, hb_ex, ha_mem, hb_mem, load_use, flush, adv, enter;
  function automatic logic hit(input logic v, input logic rw, input logic [4:0] wa,
                               input logic [4:0] r, input logic u);
    return v & rw & (wa == r) & (r != 5'd0) & u;
  endfunction
  always_comb begin
    ua = id_valid & id_uses_rs;
    ub = id_valid & id_uses_rt;
    ha_ex = hit(ex_q.v, ex_q.rw, ex_q.wa, id_rs, ua);
    hb_ex = hit(ex_q.v, ex_q.rw, ex_q.wa, id_rt, ub);
    ha_mem = hit(mem_v_q, mem_rw_q, mem_wa_q, id_rs, ua);
    hb_mem = hit(mem_v_q, mem_rw_q, mem_wa_q, id_rt, ub);
    ex_hold = cnt_q != '0;
    flush = !ex_hold & branch_taken_ex & !DELAY_SLOT;
    load_use = ex_q.ld & (ha_ex | hb_ex);
    bubble_ex = !ex_hold & (flush | load_use);
    stall_id = ex_hold | (load_use & !flush);
    flush_id = flush;
    adv = !ex_hold & !bubble_ex;
    enter = adv & id_valid;
    ex_d = ex_hold ? ex_q : {enter, id_wr_addr, id_reg_write, id_is_load, id_is_muldiv};
    mem_v_d = ex_q.v & !ex_hold;
    mem_wa_d = ex_q.wa;
    mem_rw_d = ex_q.rw;
    sa_d = !adv ? sa_q : ha_ex ? 2'b10 : ha_mem ? 2'b01 : 2'b00;
    sb_d = !adv ? sb_q : hb_ex ? 2'b10 : hb_mem ? 2'b01 : 2'b00;
    start_d = enter & id_is_muldiv;
    cnt_d = ex_hold ? cnt_q - CW'(1) : start_d ? CW'(MULDIV_LAT - 1) : '0;
    src_a_mux = sa_q;
    src_b_mux = sb_q;
    muldiv_start = start_q;
    muldiv_busy = ex_q.v & ex_q.md;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      mem_v_q <= 1'b0;
      mem_wa_q <= '0;
      mem_rw_q <= 1'b0;
      cnt_q <= '0;
      start_q <= 1'b0;
      sa_q <= 2'b00;
      sb_q <= 2'b00;
    end else begin
      ex_q <= ex_d;
      mem_v_q <= mem_v_d;
      mem_wa_q <= mem_wa_d;
      mem_rw_q <= mem_rw_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end
endmodule
